frame_backup_stack: RTL and testbench

Parametrised successor to the single-frame register backup: a LIFO of register-file snapshots. On `backup` it saves the whole register file, a frame of `NREGS*WIDTH` bits. On `restore` it returns the most recent saved frame. A simultaneous `backup` and `restore` exchanges the top frame with the live file. It sits between the register file and the control unit, and adds nesting depth, full/empty status, error flags and an optional overwrite-oldest mode.

---
 rtl/frame_backup_stack.sv | 121 ++++++++++++
 tb/tb_frame_backup_stack.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_backup_stack.sv
// LIFO of register-file snapshots with swap, full/empty status,
// error pulses and optional overwrite-oldest mode.
module frame_backup_stack #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int DEPTH = 8,
  parameter int WRAP  = 0,
  localparam int FW = NREGS * WIDTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          backup,
  input  logic          restore,
  input  logic [FW-1:0] dataIn,
  output logic [FW-1:0] dataOut,
  output logic          restoreOut,
  output logic [CW-1:0] frameCount,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          dropped,
  output logic          underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [FW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_count;
  logic [FW-1:0] r_dout;
  logic          r_ro;
  logic          r_ovf;
  logic          r_drop;
  logic          r_und;

  logic [PW-1:0] w_top_inc;
  logic [PW-1:0] w_top_dec;
  logic          w_full;
  logic          w_empty;
  logic          w_swap;
  logic          w_push;
  logic          w_pop;
  logic          w_we;
  logic [PW-1:0] w_waddr;

  assign w_top_inc = (r_top == LAST) ? '0 : r_top + PW'(1);
  assign w_top_dec = (r_top == '0) ? LAST : r_top - PW'(1);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_swap    = backup & restore;
  assign w_push    = backup & ~restore;
  assign w_pop     = restore & ~backup;

  // A swap writes in place; a push (or wrap overwrite) writes one slot up.
  assign w_we    = (w_swap & ~w_empty)
                 | (w_push & (~w_full | (WRAP != 0)));
  assign w_waddr = w_swap ? r_top : w_top_inc;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= dataIn;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_top   <= LAST;
      r_count <= '0;
      r_dout  <= '0;
      r_ro    <= 1'b0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
      r_und   <= 1'b0;
    end else begin
      r_ro   <= 1'b0;
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
      r_und  <= 1'b0;
      unique case (1'b1)
        w_swap: begin
          r_dout <= w_empty ? dataIn : r_mem[r_top];
          r_ro   <= 1'b1;
        end
        w_push: begin
          if (!w_full) begin
            r_top   <= w_top_inc;
            r_count <= r_count + CW'(1);
            r_dout  <= dataIn;
          end else if (WRAP != 0) begin
            r_top  <= w_top_inc;
            r_dout <= dataIn;
            r_drop <= 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end
        w_pop: begin
          if (!w_empty) begin
            r_dout  <= r_mem[r_top];
            r_top   <= w_top_dec;
            r_count <= r_count - CW'(1);
            r_ro    <= 1'b1;
          end else begin
            r_und <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dataOut    = r_dout;
  assign restoreOut = r_ro;
  assign frameCount = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_ovf;
  assign dropped    = r_drop;
  assign underflow  = r_und;

endmodule

// File: tb/tb_frame_backup_stack.sv
// Bench for frame_backup_stack: default stack (DEPTH=8, WRAP=0) and
// a wrapping stack (DEPTH=5, WRAP=1) driven with identical stimulus.
module tb_frame_backup_stack;

  localparam int WIDTH = 16;
  localparam int NREGS = 16;
  localparam int FW = WIDTH * NREGS;
  localparam int DA = 8;
  localparam int DB = 5;

  typedef logic [FW-1:0] frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic backup = 1'b0;
  logic restore = 1'b0;
  frame_t dataIn = '0;

  frame_t a_dout, b_dout;
  logic [3:0] a_cnt;
  logic [2:0] b_cnt;
  logic a_ro, a_full, a_empty, a_ovf, a_drop, a_und;
  logic b_ro, b_full, b_empty, b_ovf, b_drop, b_und;

  always #5 clk = ~clk;

  frame_backup_stack #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DA), .WRAP(0))
  dut_a (
    .clk(clk), .reset_n(reset_n), .backup(backup), .restore(restore),
    .dataIn(dataIn), .dataOut(a_dout), .restoreOut(a_ro),
    .frameCount(a_cnt), .full(a_full), .empty(a_empty),
    .overflow(a_ovf), .dropped(a_drop), .underflow(a_und)
  );

  frame_backup_stack #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DB), .WRAP(1))
  dut_b (
    .clk(clk), .reset_n(reset_n), .backup(backup), .restore(restore),
    .dataIn(dataIn), .dataOut(b_dout), .restoreOut(b_ro),
    .frameCount(b_cnt), .full(b_full), .empty(b_empty),
    .overflow(b_ovf), .dropped(b_drop), .underflow(b_und)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of frames per stack, newest at the back.
  frame_t mq [2][$];
  frame_t mdout [2];
  bit mro [2], movf [2], mdrop [2], mund [2];

  task automatic chk(input string name, input frame_t act, input frame_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mdout[k] = '0;
      mro[k] = 0; movf[k] = 0; mdrop[k] = 0; mund[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int dep, input bit wrap,
                            input bit b, input bit r, input frame_t d);
    mro[k] = 0; movf[k] = 0; mdrop[k] = 0; mund[k] = 0;
    if (b && r) begin
      if (mq[k].size() > 0) begin
        mdout[k] = mq[k].pop_back();
        mq[k].push_back(d);
      end else begin
        mdout[k] = d;
      end
      mro[k] = 1;
    end else if (b) begin
      if (mq[k].size() < dep) begin
        mq[k].push_back(d);
        mdout[k] = d;
      end else if (wrap) begin
        void'(mq[k].pop_front());
        mq[k].push_back(d);
        mdout[k] = d;
        mdrop[k] = 1;
      end else begin
        movf[k] = 1;
      end
    end else if (r) begin
      if (mq[k].size() > 0) begin
        mdout[k] = mq[k].pop_back();
        mro[k] = 1;
      end else begin
        mund[k] = 1;
      end
    end
  endtask

  task automatic check_models();
    chk("a.dataOut", a_dout, mdout[0]);
    chk("a.count", frame_t'(a_cnt), frame_t'(mq[0].size()));
    chk("a.full", frame_t'(a_full), frame_t'(mq[0].size() == DA));
    chk("a.empty", frame_t'(a_empty), frame_t'(mq[0].size() == 0));
    chk("a.restoreOut", frame_t'(a_ro), frame_t'(mro[0]));
    chk("a.overflow", frame_t'(a_ovf), frame_t'(movf[0]));
    chk("a.dropped", frame_t'(a_drop), frame_t'(mdrop[0]));
    chk("a.underflow", frame_t'(a_und), frame_t'(mund[0]));
    chk("b.dataOut", b_dout, mdout[1]);
    chk("b.count", frame_t'(b_cnt), frame_t'(mq[1].size()));
    chk("b.full", frame_t'(b_full), frame_t'(mq[1].size() == DB));
    chk("b.empty", frame_t'(b_empty), frame_t'(mq[1].size() == 0));
    chk("b.restoreOut", frame_t'(b_ro), frame_t'(mro[1]));
    chk("b.overflow", frame_t'(b_ovf), frame_t'(movf[1]));
    chk("b.dropped", frame_t'(b_drop), frame_t'(mdrop[1]));
    chk("b.underflow", frame_t'(b_und), frame_t'(mund[1]));
  endtask

  // Drive one command for one cycle; compare both DUTs 1 time unit after the edge.
  task automatic cyc(input bit b, input bit r, input frame_t d);
    backup = b;
    restore = r;
    dataIn = d;
    model_step(0, DA, 1'b0, b, r, d);
    model_step(1, DB, 1'b1, b, r, d);
    @(posedge clk);
    #1;
    check_models();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst.a.dataOut", a_dout, '0);
    chk("rst.a.count", frame_t'(a_cnt), '0);
    chk("rst.a.empty", frame_t'(a_empty), frame_t'(1));
    chk("rst.a.full", frame_t'(a_full), '0);
    chk("rst.a.pulses", frame_t'({a_ro, a_ovf, a_drop, a_und}), '0);
    chk("rst.b.dataOut", b_dout, '0);
    chk("rst.b.count", frame_t'(b_cnt), '0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit b;
    bit r;
    int d;
    int edout;
    int ecnt;
    bit ero;
    bit efull;
    bit eempty;
    bit eovf;
    bit eund;
  } vec_t;

  vec_t vt[$];

  function automatic void addv(bit b, bit r, int d, int edout, int ecnt,
                               bit ero, bit efull, bit eempty, bit eovf, bit eund);
    vec_t v;
    v.b = b; v.r = r; v.d = d; v.edout = edout; v.ecnt = ecnt;
    v.ero = ero; v.efull = efull; v.eempty = eempty;
    v.eovf = eovf; v.eund = eund;
    vt.push_back(v);
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int w = 0; w < FW / 32; w++) f[w*32 +: 32] = $urandom;
    return f;
  endfunction

  initial begin
    // Push/drain, underflow, then overflow on the default stack.
    for (int i = 1; i <= 8; i++) addv(1, 0, i, i, i, 0, i == 8, 0, 0, 0);
    for (int k = 1; k <= 8; k++) addv(0, 1, 0, 9 - k, 8 - k, 1, 0, k == 8, 0, 0);
    addv(0, 1, 0, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 8; i++) addv(1, 0, i, i, i, 0, i == 8, 0, 0, 0);
    addv(1, 0, 9, 8, 8, 0, 1, 0, 1, 0);
    addv(0, 1, 0, 8, 7, 1, 0, 0, 0, 0);

    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    foreach (vt[i]) begin
      cyc(vt[i].b, vt[i].r, frame_t'(vt[i].d));
      chk($sformatf("vec%0d.dataOut", i), a_dout, frame_t'(vt[i].edout));
      chk($sformatf("vec%0d.count", i), frame_t'(a_cnt), frame_t'(vt[i].ecnt));
      chk($sformatf("vec%0d.flags", i),
          frame_t'({a_ro, a_full, a_empty, a_ovf, a_und}),
          frame_t'({vt[i].ero, vt[i].efull, vt[i].eempty, vt[i].eovf, vt[i].eund}));
    end

    // Wrap stack: 1..7 into DEPTH=5 drops 1 and 2.
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 0, frame_t'(i));
      chk("wrap.dropped", frame_t'(b_drop), frame_t'(i >= 6));
    end
    chk("wrap.count", frame_t'(b_cnt), frame_t'(5));
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, '0);
      chk("wrap.pop", b_dout, frame_t'(7 - k));
    end
    cyc(0, 1, '0);
    chk("wrap.underflow", frame_t'(b_und), frame_t'(1));

    // Swap with data, then swap while empty.
    do_reset();
    cyc(1, 0, frame_t'(10));
    cyc(1, 0, frame_t'(20));
    cyc(1, 1, frame_t'(30));
    chk("swap.dataOut", a_dout, frame_t'(20));
    chk("swap.restoreOut", frame_t'(a_ro), frame_t'(1));
    chk("swap.count", frame_t'(a_cnt), frame_t'(2));
    cyc(0, 1, '0);
    chk("swap.pop1", a_dout, frame_t'(30));
    cyc(0, 1, '0);
    chk("swap.pop2", a_dout, frame_t'(10));
    cyc(1, 1, frame_t'(5));
    chk("swap.empty.dataOut", a_dout, frame_t'(5));
    chk("swap.empty.count", frame_t'(a_cnt), '0);
    chk("swap.empty.flags", frame_t'({a_ovf, a_und}), '0);

    // Reset mid-operation discards frames.
    for (int i = 1; i <= 3; i++) cyc(1, 0, frame_t'(100 + i));
    do_reset();
    cyc(0, 1, '0);
    chk("rstmid.underflow", frame_t'(a_und), frame_t'(1));
    chk("rstmid.dataOut", a_dout, '0);

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      cyc(sel < 6 || sel == 9, sel >= 5, rnd_frame());
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    backup = 0;
    restore = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
